// File: rtl/ifu_fetch_if.sv
// ifu_fetch_if: fetch-to-decode valid/ready channel carrying an instruction and its PC
interface ifu_fetch_if;
    logic        valid;
    logic        ready;
    logic [31:0] inst;
    logic [31:0] pc;
    modport master (output valid, inst, pc, input ready);
    modport slave (input valid, inst, pc, output ready);
endinterface

// File: rtl/ifu_fetch.sv
// ifu_fetch: PC owner feeding decode from a combinational ROM; define IFU_EBREAK_HALT_EN to stop on ebreak
module ifu_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h8000_0000,
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
    parameter int          MEM_WORDS = 64,
    parameter logic [31:0] NOP_INST  = 32'h0000_0013
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic [31:0]        inst_addr,
    input  logic [31:0]        inst_data,
    ifu_fetch_if.master        dec,
    input  logic               redirect_valid,
    input  logic [31:0]        redirect_pc,
    output logic               fault,
    output logic [31:0]        fault_pc,
    output logic [31:0]        fetch_cnt
`ifdef IFU_EBREAK_HALT_EN
    ,
    output logic               halt
`endif
);
`ifdef IFU_EBREAK_HALT_EN
    localparam logic [31:0] EBREAK = 32'h0010_0073;
`endif
    typedef enum logic [1:0] {
        RUN   = 2'd0,
`ifdef IFU_EBREAK_HALT_EN
        HALT  = 2'd1,
`endif
        FAULT = 2'd2
    } state_t;
    state_t      state, state_d;
    logic [31:0] pc, pc_d, inst_q, inst_d, opc_q, opc_d, fpc_d, cnt_d;
    logic        valid_q, valid_d, fault_d;
    logic [32:0] offset;
    logic        in_rng, fire;
`ifdef IFU_EBREAK_HALT_EN
    logic        halt_d;
`endif
    assign inst_addr = pc;
    assign dec.valid = valid_q;
    assign dec.inst  = inst_q;
    assign dec.pc    = opc_q;
    // 33-bit difference so a PC below the base cannot wrap into range
    assign offset = {1'b0, pc} - {1'b0, BASE_ADDR};
    assign in_rng = (pc >= BASE_ADDR) && (offset < (33'(MEM_WORDS) << 2));
    assign fire   = state == RUN && !redirect_valid && in_rng && (!valid_q || dec.ready);
    always_comb begin
        state_d = state;
        pc_d    = pc;
        valid_d = valid_q;
        inst_d  = inst_q;
        opc_d   = opc_q;
        fault_d = fault;
        fpc_d   = fault_pc;
        cnt_d   = fetch_cnt;
`ifdef IFU_EBREAK_HALT_EN
        halt_d  = halt;
`endif
        if (redirect_valid) begin
            valid_d = 1'b0;
            pc_d    = {redirect_pc[31:2], 2'b00};
            state_d = RUN;
            fault_d = 1'b0;
`ifdef IFU_EBREAK_HALT_EN
            halt_d  = 1'b0;
`endif
        end else if (state == RUN && !in_rng) begin
            state_d = FAULT;
            fault_d = 1'b1;
            fpc_d   = pc;
            valid_d = valid_q && !dec.ready;
        end else if (fire) begin
            valid_d = 1'b1;
            inst_d  = inst_data;
            opc_d   = pc;
            cnt_d   = fetch_cnt + 32'd1;
            pc_d    = pc + 32'd4;
`ifdef IFU_EBREAK_HALT_EN
            if (inst_data == EBREAK) begin
                pc_d    = pc;
                state_d = HALT;
                halt_d  = 1'b1;
            end
`endif
        end else begin
            valid_d = valid_q && !dec.ready;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RUN;
            pc        <= RESET_PC;
            valid_q   <= 1'b0;
            inst_q    <= NOP_INST;
            opc_q     <= 32'd0;
            fault     <= 1'b0;
            fault_pc  <= 32'd0;
            fetch_cnt <= 32'd0;
`ifdef IFU_EBREAK_HALT_EN
            halt      <= 1'b0;
`endif
        end else begin
            state     <= state_d;
            pc        <= pc_d;
            valid_q   <= valid_d;
            inst_q    <= inst_d;
            opc_q     <= opc_d;
            fault     <= fault_d;
            fault_pc  <= fpc_d;
            fetch_cnt <= cnt_d;
`ifdef IFU_EBREAK_HALT_EN
            halt      <= halt_d;
`endif
        end
    end
endmodule
